cursor_overlay: RTL and testbench

- Downstream consumer of the (x_pos, y_pos) offset pair produced by the button-driven position mover.
- Draws a hollow rectangular cursor outline, with optional blinking, onto the RGB pixel stream on its way to the VGA output.
- Position is sampled once per frame, on the falling edge of vsync, so the cursor never tears mid-frame.
- Fixed 2-cycle pipeline; sync and blank signals are delayed by the same amount.

---
 rtl/cursor_overlay_if.sv | 35 +++
 rtl/cursor_overlay.sv | 124 ++++++++++++
 tb/tb_cursor_overlay.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cursor_overlay_if.sv
// Video stream into and out of the cursor overlay, plus its control inputs.
interface cursor_overlay_if;
   localparam int unsigned HW = 11;
   localparam int unsigned VW = 10;
   localparam int unsigned PW = 24;

   logic          overlay_en;
   logic          blink_en;
   logic [HW-1:0] x_pos;
   logic [VW-1:0] y_pos;
   logic [HW-1:0] hcount;
   logic [VW-1:0] vcount;
   logic          hsync;
   logic          vsync;
   logic          blank;
   logic [PW-1:0] pixel_in;
   logic [PW-1:0] pixel_out;
   logic          hsync_out;
   logic          vsync_out;
   logic          blank_out;

   // Video source / controller side
   modport master (
      output overlay_en, blink_en, x_pos, y_pos,
      output hcount, vcount, hsync, vsync, blank, pixel_in,
      input  pixel_out, hsync_out, vsync_out, blank_out
   );

   // Overlay block side
   modport slave (
      input  overlay_en, blink_en, x_pos, y_pos,
      input  hcount, vcount, hsync, vsync, blank, pixel_in,
      output pixel_out, hsync_out, vsync_out, blank_out
   );
endinterface

// File: rtl/cursor_overlay.sv
// Hollow rectangular cursor drawn over an RGB pixel stream, with optional blink.
// Position is latched on vsync falling edge; fixed 2-cycle pipeline.
module cursor_overlay #(
   parameter int unsigned BOX_W        = 32,
   parameter int unsigned BOX_H        = 32,
   parameter int unsigned THICK        = 2,
   parameter logic [23:0] CURSOR_RGB   = 24'hFF0000,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input logic             clk,
   input logic             rst_n,
   cursor_overlay_if.slave bus
);
   localparam int unsigned GW = 12;
   localparam int unsigned HW = 11;
   localparam int unsigned VW = 10;
   localparam int unsigned PW = 24;
   localparam int unsigned CW = 8;

   localparam logic [GW-1:0] BW       = GW'(BOX_W);
   localparam logic [GW-1:0] BH       = GW'(BOX_H);
   localparam logic [GW-1:0] TK       = GW'(THICK);
   localparam bit            BLINK_ON = (BLINK_FRAMES != 0);
   localparam logic [CW-1:0] LAST     = CW'((BLINK_FRAMES == 0) ? 0 : BLINK_FRAMES - 1);

   logic          vsync_q;
   logic          vs_fall_c;
   logic [HW-1:0] xs;
   logic [VW-1:0] ys;
   logic [CW-1:0] frame_cnt;
   logic          vis;

   logic [GW-1:0] hx, vy, x0, x1, y0, y1, xi0, xi1, yi0, yi1;
   logic          in_box_c, in_inner_c, on_edge_c;

   logic          edge_r;
   logic [PW-1:0] pixel_r;
   logic          hsync_r, vsync_r, blank_r;
   logic          draw_c;

   assign vs_fall_c = vsync_q & ~bus.vsync;

   // Once-per-frame shadow position and blink phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q   <= 1'b0;
         xs        <= '0;
         ys        <= '0;
         frame_cnt <= '0;
         vis       <= 1'b1;
      end else begin
         vsync_q <= bus.vsync;
         if (vs_fall_c) begin
            xs <= bus.x_pos;
            ys <= bus.y_pos;
            if (bus.blink_en && BLINK_ON) begin
               if (frame_cnt == LAST) begin
                  frame_cnt <= '0;
                  vis       <= ~vis;
               end else begin
                  frame_cnt <= frame_cnt + CW'(1);
               end
            end else begin
               frame_cnt <= '0;
               vis       <= 1'b1;
            end
         end
      end
   end

   // Outline hit test in 12-bit space so the box end never wraps
   always_comb begin
      hx  = {1'b0, bus.hcount};
      vy  = {2'b00, bus.vcount};
      x0  = {1'b0, xs};
      y0  = {2'b00, ys};
      x1  = x0 + BW;
      y1  = y0 + BH;
      xi0 = x0 + TK;
      xi1 = x1 - TK;
      yi0 = y0 + TK;
      yi1 = y1 - TK;
      in_box_c   = (hx >= x0) && (hx < x1) && (vy >= y0) && (vy < y1);
      in_inner_c = (hx >= xi0) && (hx < xi1) && (vy >= yi0) && (vy < yi1);
      on_edge_c  = in_box_c && !in_inner_c;
   end

   // Stage 1: capture hit and the video stream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_r  <= 1'b0;
         pixel_r <= '0;
         hsync_r <= 1'b0;
         vsync_r <= 1'b0;
         blank_r <= 1'b0;
      end else begin
         edge_r  <= on_edge_c;
         pixel_r <= bus.pixel_in;
         hsync_r <= bus.hsync;
         vsync_r <= bus.vsync;
         blank_r <= bus.blank;
      end
   end

   // Blanked pixels are never painted
   always_comb begin
      draw_c = edge_r & bus.overlay_en & vis & ~blank_r;
   end

   // Stage 2: colour select and aligned sync/blank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.pixel_out <= '0;
         bus.hsync_out <= 1'b0;
         bus.vsync_out <= 1'b0;
         bus.blank_out <= 1'b0;
      end else begin
         bus.pixel_out <= draw_c ? CURSOR_RGB : pixel_r;
         bus.hsync_out <= hsync_r;
         bus.vsync_out <= vsync_r;
         bus.blank_out <= blank_r;
      end
   end
endmodule

// File: tb/tb_cursor_overlay.sv
// Directed bench for cursor_overlay; expected outputs are hand-computed.
module tb_cursor_overlay;
   localparam logic [23:0] RED = 24'hFF0000;

   typedef struct {
      int          h;
      int          v;
      logic [23:0] pin;
      logic [23:0] exp;
   } vec_t;

   typedef struct {
      logic        v;
      logic [23:0] pix;
      logic        hs;
      logic        vs;
      logic        bl;
      int          h;
      int          vc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   exp_t e0, e1, e2;
   vec_t tab_a[14];

   cursor_overlay_if bus ();

   cursor_overlay #(
      .BOX_W(32), .BOX_H(32), .THICK(2), .CURSOR_RGB(24'hFF0000), .BLINK_FRAMES(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expectations travel two clocks, flushed by reset like the DUT pipeline
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e1.v <= 1'b0;
         e2.v <= 1'b0;
      end else begin
         e1 <= e0;
         e2 <= e1;
      end
   end

   task automatic chk(input string name, input logic [26:0] act, input logic [26:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got {pix,hs,vs,bl}=%h, want %h", name, act, want);
      end
   endtask

   // One pixel per call; also checks the vector issued two clocks earlier
   task automatic drive(input int h, input int v, input logic hs, input logic vs,
                        input logic bl, input logic [23:0] pin, input logic [23:0] ex);
      @(negedge clk);
      if (e2.v)
         chk($sformatf("px(%0d,%0d)", e2.h, e2.vc),
             {bus.pixel_out, bus.hsync_out, bus.vsync_out, bus.blank_out},
             {e2.pix, e2.hs, e2.vs, e2.bl});
      bus.hcount   = 11'(h);
      bus.vcount   = 10'(v);
      bus.hsync    = hs;
      bus.vsync    = vs;
      bus.blank    = bl;
      bus.pixel_in = pin;
      e0 = '{1'b1, ex, hs, vs, bl, h, v};
   endtask

   task automatic px(input int h, input int v, input logic [23:0] ex);
      drive(h, v, 1'b1, 1'b1, 1'b0, 24'h0, ex);
   endtask

   // Blanked vsync pulse; the falling edge latches x_pos/y_pos
   task automatic new_frame();
      drive(0, 0, 1'b1, 1'b1, 1'b1, 24'h0, 24'h0);
      drive(0, 0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0);
      drive(0, 0, 1'b1, 1'b0, 1'b1, 24'h0, 24'h0);
      drive(0, 0, 1'b1, 1'b1, 1'b1, 24'h0, 24'h0);
   endtask

   task automatic idle2();
      drive(700, 300, 1'b0, 1'b1, 1'b1, 24'h0, 24'h0);
      drive(700, 300, 1'b0, 1'b1, 1'b1, 24'h0, 24'h0);
   endtask

   initial begin
      logic [23:0] r;
      int          hh;
      logic        vis_exp;
      n_vec = 0;
      n_err = 0;
      e0 = '{1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 0, 0};
      tab_a[0]  = '{100, 50, 24'h000000, RED};
      tab_a[1]  = '{131, 50, 24'h000000, RED};
      tab_a[2]  = '{132, 50, 24'h000000, 24'h000000};
      tab_a[3]  = '{ 99, 50, 24'h000000, 24'h000000};
      tab_a[4]  = '{100, 60, 24'h555555, RED};
      tab_a[5]  = '{101, 60, 24'h000000, RED};
      tab_a[6]  = '{102, 60, 24'h000000, 24'h000000};
      tab_a[7]  = '{110, 60, 24'h123456, 24'h123456};
      tab_a[8]  = '{110, 81, 24'h000000, RED};
      tab_a[9]  = '{110, 82, 24'h000000, 24'h000000};
      tab_a[10] = '{130, 70, 24'h000000, RED};
      tab_a[11] = '{129, 70, 24'h000000, 24'h000000};
      tab_a[12] = '{110, 49, 24'hABCDEF, 24'hABCDEF};
      tab_a[13] = '{110, 51, 24'h000000, RED};

      rst_n = 1'b0;
      bus.overlay_en = 1'b1;
      bus.blink_en   = 1'b0;
      bus.x_pos      = 11'd100;
      bus.y_pos      = 10'd50;
      bus.hcount     = '0;
      bus.vcount     = '0;
      bus.hsync      = 1'b1;
      bus.vsync      = 1'b1;
      bus.blank      = 1'b1;
      bus.pixel_in   = 24'h0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {bus.pixel_out, bus.hsync_out, bus.vsync_out, bus.blank_out}, 27'h0);
      rst_n = 1'b1;

      // Basic frame at (100,50)
      new_frame();
      for (int i = 0; i < 14; i++)
         drive(tab_a[i].h, tab_a[i].v, 1'(i % 2), 1'b1, 1'b0, tab_a[i].pin, tab_a[i].exp);

      // Position change mid-frame waits for the next vsync edge
      px(100, 55, RED);
      bus.x_pos = 11'd200;
      px(100, 56, RED);
      px(200, 56, 24'h0);
      new_frame();
      px(200, 56, RED);
      px(100, 56, 24'h0);

      // Hit in the same cycle as vs_fall still uses the old position
      bus.x_pos = 11'd300;
      drive(200, 56, 1'b1, 1'b0, 1'b0, 24'h0, RED);
      drive(200, 56, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
      drive(300, 56, 1'b1, 1'b0, 1'b0, 24'h0, RED);
      drive(0, 0, 1'b1, 1'b1, 1'b1, 24'h0, 24'h0);

      // Box clipped at the right/bottom edge, no wrap-around
      bus.x_pos = 11'd620;
      bus.y_pos = 10'd470;
      new_frame();
      px(620, 470, RED);
      px(639, 470, RED);
      px(621, 479, RED);
      px(625, 479, 24'h0);
      drive(640, 470, 1'b0, 1'b1, 1'b1, 24'h0, 24'h0);
      drive(645, 471, 1'b0, 1'b1, 1'b1, 24'h0, 24'h0);
      new_frame();
      for (int v = 0; v < 2; v++)
         for (int h = 0; h < 12; h++)
            px(h, v, 24'h0);

      // Blink with half-period of 2 frames
      bus.x_pos = 11'd100;
      bus.y_pos = 10'd50;
      new_frame();
      bus.blink_en = 1'b1;
      for (int f = 1; f <= 11; f++) begin
         if (f > 1) new_frame();
         vis_exp = (((f - 1) / 2) % 2) == 0;
         px(100, 50, vis_exp ? RED : 24'h0);
         px(110, 60, 24'h0);
      end
      bus.blink_en = 1'b0;
      new_frame();
      px(100, 50, RED);

      // Overlay disabled: bit-exact pass-through
      idle2();
      bus.overlay_en = 1'b0;
      for (int i = 0; i < 40; i++) begin
         r  = 24'($urandom);
         hh = int'($urandom_range(95, 140));
         drive(hh, 50, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), r, r);
      end
      idle2();
      bus.overlay_en = 1'b1;

      // Asynchronous reset mid-line
      bus.x_pos = 11'd300;
      bus.y_pos = 10'd200;
      repeat (3) drive(500, 300, 1'b1, 1'b1, 1'b0, 24'hABCDEF, 24'hABCDEF);
      @(negedge clk);
      chk("pre_reset_pixel", {3'b0, bus.pixel_out}, {3'b0, 24'hABCDEF});
      #2;
      rst_n = 1'b0;
      e0.v = 1'b0;
      #1;
      chk("async_reset_pixel", {3'b0, bus.pixel_out}, 27'h0);
      chk("async_reset_sync", {24'h0, bus.hsync_out, bus.vsync_out, bus.blank_out}, 27'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      px(0, 0, RED);
      px(1, 1, RED);
      px(2, 2, 24'h0);
      px(31, 10, RED);
      new_frame();
      px(300, 200, RED);
      px(0, 0, 24'h0);
      px(331, 231, RED);
      idle2();
      idle2();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
